// File: rtl/mips_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_fetch_unit
// Purpose  : PC owner and single-outstanding instruction fetch feeding the
//            decoder. `define MIPS_FETCH_PERF_CNT_EN adds fetch/stall counters.
// Revision : 1.0  initial release
// ============================================================================
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic        is_jump,
  input  logic [15:0] immediate,
  input  logic [25:0] jump_imm_addr
`ifdef MIPS_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        consume;

  // Target selection; jump outranks a taken branch.
  always_comb begin
    pc4    = pc_q + 32'd4;
    br_off = {{14{immediate[15]}}, immediate, 2'b00};
    if (is_jump) begin
      next_pc = {pc4[31:28], jump_imm_addr, 2'b00};
    end else if (is_branch && branch_taken) begin
      next_pc = pc4 + br_off;
    end else begin
      next_pc = pc4;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    consume        = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = S_WAIT;
      end
      // Responses are only honoured here, so stale or early data is dropped.
      S_WAIT: begin
        if (imem_resp_valid) begin
          instr_d = imem_resp_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          consume = 1'b1;
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;

`ifdef MIPS_FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + {31'd0, consume};
    stall_count_d = stall_count_q + {31'd0, inst_valid & ~inst_ready};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
`default_nettype none
// Bench for mips_fetch_unit: protocol-level reference model checked every
// cycle, randomized memory/decoder stimulus, plus literal anchor checks.
module tb_mips_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        is_branch;
  logic        branch_taken;
  logic        is_jump;
  logic [15:0] immediate;
  logic [25:0] jump_imm_addr;
`ifdef MIPS_FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  mips_fetch_unit #(.RESET_PC(RESET_PC)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .pc             (pc),
    .is_branch      (is_branch),
    .branch_taken   (branch_taken),
    .is_jump        (is_jump),
    .immediate      (immediate),
    .jump_imm_addr  (jump_imm_addr)
`ifdef MIPS_FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0005 ^ (a * 32'h9E37_79B9);
  endfunction

  // Next PC straight from the ISA rules, with ordinary integer arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic j, input logic b,
                                             input logic t, input logic [15:0] imm,
                                             input logic [25:0] ja);
    logic [31:0]        seq;
    logic signed [15:0] simm;
    int                 off;
    seq  = p + 32'd4;
    simm = imm;
    off  = simm;
    if (j) return (seq & 32'hF000_0000) | ({6'd0, ja} << 2);
    if (b && t) return seq + 32'(off * 4);
    return seq;
  endfunction

  // ---------------- memory responder ----------------
  logic        mem_always  = 1'b1;
  logic        mem_hold_low = 1'b0;
  logic        stale_mode  = 1'b0;
  logic        spurious_en = 1'b0;
  int          dly_min = 0;
  int          dly_max = 0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;

  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = pend_data;
          pend            = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (mem_hold_low)    imem_req_ready = 1'b0;
      else if (mem_always) imem_req_ready = 1'b1;
      else                 imem_req_ready = ($urandom_range(3) != 0);
      if (imem_req_valid && imem_req_ready && rst_n) begin
        pend      = 1'b1;
        pend_cnt  = int'($urandom_range(dly_max, dly_min));
        pend_data = stale_mode ? 32'hDEAD_BEEF : mem_word(imem_addr);
      end
      // Unsolicited response while nothing is outstanding.
      if (spurious_en && !imem_resp_valid && !pend && $urandom_range(7) == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_0000 ^ $urandom;
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_inst = '0;
  logic        m_outst = 1'b0;
  logic        p_iv = 1'b0, p_rv = 1'b0;
  int          since_rst = 0;
  logic [31:0] m_fc = '0, m_sc = '0;

  initial begin
    logic consumed, accepted, e_iv, e_rv;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_pc", pc, RESET_PC);
        check("rst_instruction", instruction, 32'd0);
        m_pc = RESET_PC; m_outst = 1'b0; p_iv = 1'b0; p_rv = 1'b0;
        since_rst = 0; m_fc = '0; m_sc = '0;
`ifdef MIPS_FETCH_PERF_CNT_EN
        check("rst_fetch_count", fetch_count, 32'd0);
        check("rst_stall_count", stall_count, 32'd0);
`endif
      end else begin
        since_rst++;
        consumed = p_iv && inst_ready;
        accepted = p_rv && imem_req_ready;
        e_iv = p_iv ? !inst_ready : (m_outst && imem_resp_valid);
        e_rv = p_rv ? !imem_req_ready : (consumed || since_rst == 2);
        if (m_outst && imem_resp_valid) begin
          m_inst  = imem_resp_data;
          m_outst = 1'b0;
        end
        if (accepted) m_outst = 1'b1;
        if (consumed) begin
          m_pc = model_next(m_pc, is_jump, is_branch, branch_taken, immediate, jump_imm_addr);
          m_fc = m_fc + 32'd1;
        end
        if (p_iv && !inst_ready) m_sc = m_sc + 32'd1;
        check("inst_valid", {31'd0, inst_valid}, {31'd0, e_iv});
        check("imem_req_valid", {31'd0, imem_req_valid}, {31'd0, e_rv});
        check("imem_addr", imem_addr, m_pc);
        check("pc", pc, m_pc);
        if (inst_valid) check("instruction", instruction, m_inst);
`ifdef MIPS_FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, m_fc);
        check("stall_count", stall_count, m_sc);
`endif
        p_iv = inst_valid;
        p_rv = imem_req_valid;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_dec(input logic j, input logic b, input logic t,
                         input logic [15:0] imm, input logic [25:0] ja);
    is_jump = j; is_branch = b; branch_taken = t; immediate = imm; jump_imm_addr = ja;
  endtask

  task automatic rand_dec();
    set_dec($urandom_range(5) == 0, $urandom_range(2) == 0, 1'($urandom),
            16'($urandom), 26'($urandom));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!inst_valid && n < 60);
    if (!inst_valid) check("inst_valid_timeout", {31'd0, inst_valid}, 32'd1);
  endtask

  task automatic consume(input logic j, input logic b, input logic t,
                         input logic [15:0] imm, input logic [25:0] ja);
    #1;
    inst_ready = 1'b1;
    set_dec(j, b, t, imm, ja);
    @(negedge clk);
    #1;
    inst_ready = 1'b0;
    rand_dec();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
`ifdef MIPS_FETCH_PERF_CNT_EN
    logic [31:0] f0, s0;
`endif
    rst_n = 1'b0;
    inst_ready = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // First fetch after reset, one dead cycle, then request at RESET_PC.
    @(negedge clk);
    check("dead_cycle_req", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk);
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_addr, 32'h0);
    wait_valid(lat);
    check("first_instruction", instruction, 32'h2008_0005);
    check("first_pc", pc, 32'h0);
    consume(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
    check("seq_pc4", imem_addr, 32'h4);
    wait_valid(lat);
    check("consume_to_valid_edges", 32'(lat + 1), 32'd3);

    // Branch taken / not taken from pc 0x10.
    consume(1'b1, 1'b0, 1'b0, 16'd0, 26'h4);
    check("jump_to_10", imem_addr, 32'h10);
    wait_valid(lat);
    consume(1'b0, 1'b1, 1'b1, 16'hFFFC, 26'd0);
    check("branch_taken_back", imem_addr, 32'h4);
    wait_valid(lat);
    consume(1'b1, 1'b0, 1'b0, 16'd0, 26'h4);
    wait_valid(lat);
    consume(1'b0, 1'b1, 1'b0, 16'hFFFC, 26'd0);
    check("branch_not_taken", imem_addr, 32'h14);
    wait_valid(lat);

    // Jump beats a simultaneously taken branch.
    consume(1'b1, 1'b0, 1'b0, 16'd0, 26'h4);
    wait_valid(lat);
    consume(1'b1, 1'b1, 1'b1, 16'hFFFC, 26'h40);
    check("jump_priority", imem_addr, 32'h100);
    wait_valid(lat);

    // Backward branch wraps below zero; a jump there keeps the 0xF region.
    consume(1'b0, 1'b1, 1'b1, 16'h8000, 26'd0);
    check("branch_wrap", imem_addr, 32'hFFFE_0104);
    wait_valid(lat);
    consume(1'b1, 1'b1, 1'b1, 16'h1234, 26'h40);
    check("jump_keeps_nibble", imem_addr, 32'hF000_0100);
    wait_valid(lat);

    // Decoder stalls for four cycles.
`ifdef MIPS_FETCH_PERF_CNT_EN
    f0 = fetch_count;
    s0 = stall_count;
`endif
    repeat (4) @(negedge clk);
    check("hold_valid", {31'd0, inst_valid}, 32'd1);
    check("hold_pc", pc, 32'hF000_0100);
    check("hold_instruction", instruction, mem_word(32'hF000_0100));
    #2;
    stale_mode = 1'b1;
    dly_min = 3;
    dly_max = 3;
    consume(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
`ifdef MIPS_FETCH_PERF_CNT_EN
    check("stall_delta", stall_count - s0, 32'd4);
    check("fetch_delta", fetch_count - f0, 32'd1);
`endif

    // Reset while waiting on memory; the late response must be dropped.
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while ((imem_req_valid || inst_valid) && lat < 20);
    check("reached_wait", {30'd0, imem_req_valid, inst_valid}, 32'd0);
    #2;
    mem_hold_low = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("req_held_not_ready", {31'd0, imem_req_valid}, 32'd1);
      check("req_addr_stable", imem_addr, RESET_PC);
    end
    #2;
    stale_mode = 1'b0;
    dly_min = 0;
    dly_max = 0;
    mem_hold_low = 1'b0;
    wait_valid(lat);
    check("refetch_instruction", instruction, 32'h2008_0005);
    check("refetch_pc", pc, RESET_PC);

    // Randomized traffic with slow memory, stray responses and one reset.
    #2;
    mem_always = 1'b0;
    dly_max = 2;
    spurious_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (c == 700) begin
        pulse_reset();
      end else begin
        #1;
        inst_ready = ($urandom_range(2) != 0);
        rand_dec();
      end
    end
    inst_ready = 1'b0;
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
